pulse_gen: RTL

- Generates a periodic pulse with programmable period and high-time (width), both in clk cycles.
- It is the transmit-side counterpart of the pulse period/width measurement path, and uses the same 32-bit period/width semantics.
- Used as a stimulus source on the sig_acq board and as a loop-back source for self-test of the measurement path.
- Configuration is double-buffered. New values take effect only at a period boundary, so the output never contains a truncated or glitched pulse.

---
 rtl/pulse_gen_pkg.sv | 17 +
 rtl/pulse_gen_if.sv | 46 ++++
 rtl/pulse_gen_cfg.sv | 83 ++++++++
 rtl/pulse_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared types and defaults for the pulse generator slice.
//   state_t        : generator FSM states (IDLE, RUN, DRAIN)
//   CNT_W_DEF      : default width of period/width/cycle counters
//   MIN_PERIOD_DEF : default smallest accepted period (cycles)
// Optional feature macro: PULSE_GEN_BURST_EN (burst mode, see pulse_gen.sv).
package pulse_gen_pkg;

    localparam int unsigned CNT_W_DEF      = 32;
    localparam int unsigned MIN_PERIOD_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_gen_if.sv
// pulse_gen_if: control/status bundle of the pulse generator.
//   ena, cfg_load, period_i, width_i             : requests into the generator
//   pulse, edge_l2h, edge_h2l, busy, cfg_err,
//   period_cnt                                   : generator outputs
//   burst_n, burst_done                          : only with PULSE_GEN_BURST_EN
// Modports: master = controller side, slave = generator side.
interface pulse_gen_if
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             ena;
    logic             cfg_load;
    logic [CNT_W-1:0] period_i;
    logic [CNT_W-1:0] width_i;
    logic             pulse;
    logic             edge_l2h;
    logic             edge_h2l;
    logic             busy;
    logic             cfg_err;
    logic [CNT_W-1:0] period_cnt;
`ifdef PULSE_GEN_BURST_EN
    logic [15:0]      burst_n;
    logic             burst_done;
`endif

    modport master (
`ifdef PULSE_GEN_BURST_EN
        output burst_n,
        input  burst_done,
`endif
        output ena, cfg_load, period_i, width_i,
        input  pulse, edge_l2h, edge_h2l, busy, cfg_err, period_cnt
    );

    modport slave (
`ifdef PULSE_GEN_BURST_EN
        input  burst_n,
        output burst_done,
`endif
        input  ena, cfg_load, period_i, width_i,
        output pulse, edge_l2h, edge_h2l, busy, cfg_err, period_cnt
    );

endinterface

// File: rtl/pulse_gen_cfg.sv
// pulse_gen_cfg: double-buffered configuration for pulse_gen.
//   clk, rst        : clock, synchronous active-low reset
//   cfg_load        : strobe capturing period_i/width_i (and burst_n) into pending
//   xfer            : copy pending into active (only issued while pend_valid)
//   act_period/width: configuration used by the running generator
//   pend_width      : pending width, needed for the first cycle after a transfer
//   pend_valid      : pending holds values not yet transferred
//   cfg_err         : sticky reject flag, cleared by the next accepted load
// Optional: PULSE_GEN_BURST_EN adds burst_n / act_burst.
module pulse_gen_cfg
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] width_i,
`ifdef PULSE_GEN_BURST_EN
    input  logic [15:0]      burst_n,
    output logic [15:0]      act_burst,
`endif
    input  logic             xfer,
    output logic [CNT_W-1:0] act_period,
    output logic [CNT_W-1:0] act_width,
    output logic [CNT_W-1:0] pend_width,
    output logic             pend_valid,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    logic [CNT_W-1:0] pend_period;
    logic             accept;
`ifdef PULSE_GEN_BURST_EN
    logic [15:0]      pend_burst;
`endif

    assign accept = cfg_load && (period_i >= MIN_P);

    // A transfer always takes the pending values as they were before this
    // edge, so a load coinciding with a boundary stays pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            act_period  <= '0;
            act_width   <= '0;
            pend_period <= '0;
            pend_width  <= '0;
            pend_valid  <= 1'b0;
            cfg_err     <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
            act_burst   <= '0;
            pend_burst  <= '0;
`endif
        end else begin
            if (xfer) begin
                act_period <= pend_period;
                act_width  <= pend_width;
`ifdef PULSE_GEN_BURST_EN
                act_burst  <= pend_burst;
`endif
            end
            if (accept) begin
                pend_period <= period_i;
                pend_width  <= width_i;
`ifdef PULSE_GEN_BURST_EN
                pend_burst  <= burst_n;
`endif
            end
            if (accept) begin
                pend_valid <= 1'b1;
            end else if (xfer) begin
                pend_valid <= 1'b0;
            end
            if (cfg_load) begin
                cfg_err <= !accept;
            end
        end
    end

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: periodic pulse generator with programmable period and high time.
//   clk, rst : clock, synchronous active-low reset
//   bus      : pulse_gen_if.slave
//     ena        run request (level)
//     cfg_load   capture period_i/width_i into pending configuration
//     pulse      registered output pulse
//     edge_l2h   strobe in the cycle pulse rises
//     edge_h2l   strobe in the cycle pulse falls
//     busy       generator in RUN or DRAIN
//     cfg_err    sticky rejected-load flag
//     period_cnt completed periods since leaving IDLE (wraps)
// Optional macro PULSE_GEN_BURST_EN: stop after burst_n periods and strobe
// burst_done; a restart then needs ena to drop and rise again.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    pulse_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] pcnt, pcnt_n;
    logic             pulse_q, pulse_n;
    logic             l2h_q, h2l_q;
    logic [CNT_W-1:0] width_eff;
    logic [CNT_W-1:0] act_period, act_width, pend_width;
    logic             pend_valid, cfg_err;
    logic             start, wrap, xfer;
`ifdef PULSE_GEN_BURST_EN
    logic [15:0]      act_burst;
    logic [15:0]      bcnt, bcnt_n;
    logic             bhold, bhold_n;
    logic             bdone_q, bdone_n;
`endif

    pulse_gen_cfg #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_cfg (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (bus.cfg_load),
        .period_i   (bus.period_i),
        .width_i    (bus.width_i),
`ifdef PULSE_GEN_BURST_EN
        .burst_n    (bus.burst_n),
        .act_burst  (act_burst),
`endif
        .xfer       (xfer),
        .act_period (act_period),
        .act_width  (act_width),
        .pend_width (pend_width),
        .pend_valid (pend_valid),
        .cfg_err    (cfg_err)
    );

`ifdef PULSE_GEN_BURST_EN
    assign start = (state == IDLE) && bus.ena && !bhold &&
                   (pend_valid || (act_period >= MIN_P));
`else
    assign start = (state == IDLE) && bus.ena &&
                   (pend_valid || (act_period >= MIN_P));
`endif
    assign wrap = (state != IDLE) && (cnt == act_period - ONE);
    assign xfer = pend_valid && (start || wrap);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pcnt_n    = pcnt;
        pulse_n   = 1'b0;
        width_eff = act_width;
`ifdef PULSE_GEN_BURST_EN
        bcnt_n  = bcnt;
        bhold_n = bus.ena ? bhold : 1'b0;
        bdone_n = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    pcnt_n  = '0;
                    if (pend_valid) begin
                        width_eff = pend_width;
                    end
                    pulse_n = (width_eff != '0);
`ifdef PULSE_GEN_BURST_EN
                    bcnt_n = '0;
`endif
                end
            end
            RUN, DRAIN: begin
                // A new configuration governs the pulse from the first cycle
                // of the period it starts.
                if (wrap) begin
                    cnt_n  = '0;
                    pcnt_n = pcnt + ONE;
                    if (pend_valid) begin
                        width_eff = pend_width;
                    end
                end else begin
                    cnt_n = cnt + ONE;
                end
                // ena dropping on the last cycle of a period ends the run at
                // that boundary instead of draining one more full period.
                if (state == RUN) begin
                    if (!bus.ena) begin
                        state_n = wrap ? IDLE : DRAIN;
                    end
                end else if (bus.ena) begin
                    state_n = RUN;
                end else if (wrap) begin
                    state_n = IDLE;
                end
`ifdef PULSE_GEN_BURST_EN
                if (wrap) begin
                    bcnt_n = bcnt + 16'd1;
                    if ((act_burst != '0) && (bcnt == act_burst - 16'd1)) begin
                        state_n = IDLE;
                        bdone_n = 1'b1;
                        bhold_n = 1'b1;
                    end
                end
`endif
                pulse_n = (cnt_n < width_eff);
                if (state_n == IDLE) begin
                    pulse_n = 1'b0;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pcnt    <= '0;
            pulse_q <= 1'b0;
            l2h_q   <= 1'b0;
            h2l_q   <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
            bcnt    <= '0;
            bhold   <= 1'b0;
            bdone_q <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pcnt    <= pcnt_n;
            pulse_q <= pulse_n;
            // Edges come only from the pulse register itself, so a width
            // change at a boundary cannot produce a double strobe.
            l2h_q   <= pulse_n && !pulse_q;
            h2l_q   <= !pulse_n && pulse_q;
`ifdef PULSE_GEN_BURST_EN
            bcnt    <= bcnt_n;
            bhold   <= bhold_n;
            bdone_q <= bdone_n;
`endif
        end
    end

    assign bus.pulse      = pulse_q;
    assign bus.edge_l2h   = l2h_q;
    assign bus.edge_h2l   = h2l_q;
    assign bus.busy       = (state != IDLE);
    assign bus.cfg_err    = cfg_err;
    assign bus.period_cnt = pcnt;
`ifdef PULSE_GEN_BURST_EN
    assign bus.burst_done = bdone_q;
`endif

endmodule
